// File: rtl/frog_game_state.sv
`default_nettype none
// ============================================================================
// Module   : frog_game_state
// Purpose  : Game-rules stage for the frog game. Sits downstream of the
//            player position block and the car/collision checker. Keeps the
//            two-digit BCD score and the life count, runs the
//            IDLE / PLAYING / HIT / GAME_OVER state machine, and drives the
//            respawn request and the sprite flash enable.
//
// Ports    : i_Clk        system clock (25 MHz)
//            i_Rst_n      synchronous active-low reset
//            i_Start      debounced start button, acts on release (1->0)
//            i_Player_X   player column (informational, not used by rules)
//            i_Player_Y   player row; GOAL_ROW marks the far bank
//            i_Collision  player cell overlaps a car this cycle
//            o_Score_Tens BCD tens digit of the score
//            o_Score_Ones BCD ones digit of the score
//            o_Lives      remaining lives
//            o_State      00 IDLE, 01 PLAYING, 10 HIT, 11 GAME_OVER
//            o_Respawn    one-cycle pulse: return the player to the start
//            o_Flash      sprite blink enable (high for the whole HIT phase)
//            o_Game_Over  high while in GAME_OVER
//            o_Hi_Tens    high-score tens digit  (FROG_GAME_STATE_HISCORE_EN)
//            o_Hi_Ones    high-score ones digit  (FROG_GAME_STATE_HISCORE_EN)
//
// Options  : define FROG_GAME_STATE_HISCORE_EN to add the high-score register
//            and its two output ports.
//
// Revision : 1.0  initial release
// ============================================================================
module frog_game_state #(
    parameter int LIVES_INIT  = 3,          // lives loaded on game start (1..3)
    parameter int GOAL_ROW    = 1,          // player row of the far bank
    parameter int FLASH_TICKS = 12500000    // cycles spent in HIT (>= 2)
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  logic [9:0] i_Player_X,
    input  logic [9:0] i_Player_Y,
    input  logic       i_Collision,
    output logic [3:0] o_Score_Tens,
    output logic [3:0] o_Score_Ones,
    output logic [1:0] o_Lives,
    output logic [1:0] o_State,
    output logic       o_Respawn,
    output logic       o_Flash,
`ifdef FROG_GAME_STATE_HISCORE_EN
    output logic [3:0] o_Hi_Tens,
    output logic [3:0] o_Hi_Ones,
`endif
    output logic       o_Game_Over
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The HIT counter only has to reach FLASH_TICKS-1, so clog2(FLASH_TICKS)
    // bits are always enough (24 bits at the 12.5 M default).
    localparam int               c_CNT_W       = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_FLASH_LAST = c_CNT_W'(FLASH_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [1:0]       c_LIVES_INIT  = 2'(LIVES_INIT);
    localparam logic [9:0]       c_GOAL_ROW    = 10'(GOAL_ROW);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAYING   = 2'b01,
        ST_HIT       = 2'b10,
        ST_GAME_OVER = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [3:0]          r_score_tens;
    logic [3:0]          r_score_ones;
    logic [1:0]          r_lives;
    logic                r_respawn;
    logic                r_flash;
    logic                r_game_over;
    logic [c_CNT_W-1:0]  r_flash_cnt;
    logic                r_start;       // previous i_Start, for release detection
    logic                r_goal;        // previous "on goal row", for entry detection
`ifdef FROG_GAME_STATE_HISCORE_EN
    logic [3:0]          r_hi_tens;
    logic [3:0]          r_hi_ones;
`endif

    // ------------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [3:0]          w_score_tens_nxt;
    logic [3:0]          w_score_ones_nxt;
    logic [1:0]          w_lives_nxt;
    logic                w_respawn_nxt;
    logic                w_flash_nxt;
    logic                w_game_over_nxt;
    logic [c_CNT_W-1:0]  w_flash_cnt_nxt;
`ifdef FROG_GAME_STATE_HISCORE_EN
    logic [3:0]          w_hi_tens_nxt;
    logic [3:0]          w_hi_ones_nxt;
    logic                w_score_gt_hi;
`endif

    logic                w_at_goal;
    logic                w_goal_evt;
    logic                w_start_evt;
    logic [3:0]          w_inc_tens;
    logic [3:0]          w_inc_ones;

    // The player column plays no part in the rules; it is folded into an
    // unused reduction so the port stays connected without a dangling input.
    logic                w_unused;
    assign w_unused = ^i_Player_X;

    // ------------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------------
    // The start button acts on release so a held button cannot retrigger.
    assign w_start_evt = r_start & ~i_Start;

    // The player block only holds Y on the goal row for a single cycle, but a
    // rising-edge detector still guarantees one point per crossing even if it
    // were held longer.
    assign w_at_goal   = (i_Player_Y == c_GOAL_ROW);
    assign w_goal_evt  = w_at_goal & ~r_goal;

    // ------------------------------------------------------------------------
    // Saturating BCD score increment (99 holds at 99)
    // ------------------------------------------------------------------------
    always_comb begin
        w_inc_tens = r_score_tens;
        w_inc_ones = r_score_ones;
        if ((r_score_tens == 4'd9) && (r_score_ones == 4'd9)) begin
            w_inc_tens = r_score_tens;
            w_inc_ones = r_score_ones;
        end else if (r_score_ones == 4'd9) begin
            w_inc_ones = 4'd0;
            w_inc_tens = r_score_tens + 4'd1;
        end else begin
            w_inc_ones = r_score_ones + 4'd1;
        end
    end

`ifdef FROG_GAME_STATE_HISCORE_EN
    // BCD magnitude compare: tens digit decides unless equal.
    assign w_score_gt_hi = (r_score_tens > r_hi_tens) ||
                           ((r_score_tens == r_hi_tens) && (r_score_ones > r_hi_ones));
`endif

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_score_tens_nxt = r_score_tens;
        w_score_ones_nxt = r_score_ones;
        w_lives_nxt      = r_lives;
        w_respawn_nxt    = 1'b0;
        w_flash_cnt_nxt  = r_flash_cnt;
`ifdef FROG_GAME_STATE_HISCORE_EN
        w_hi_tens_nxt    = r_hi_tens;
        w_hi_ones_nxt    = r_hi_ones;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_nxt      = ST_PLAYING;
                    w_score_tens_nxt = 4'd0;
                    w_score_ones_nxt = 4'd0;
                    w_lives_nxt      = c_LIVES_INIT;
                    w_flash_cnt_nxt  = '0;
                end
            end

            ST_PLAYING: begin
                // The goal row is a safe cell: a goal in the same cycle as a
                // collision scores and the collision is dropped.
                if (w_goal_evt) begin
                    w_score_tens_nxt = w_inc_tens;
                    w_score_ones_nxt = w_inc_ones;
                end else if (i_Collision) begin
                    if (r_lives > 2'd1) begin
                        w_lives_nxt     = r_lives - 2'd1;
                        w_respawn_nxt   = 1'b1;
                        w_flash_cnt_nxt = '0;
                        w_state_nxt     = ST_HIT;
                    end else begin
                        // Last life: no respawn, the frog stays where it died.
                        w_lives_nxt = 2'd0;
                        w_state_nxt = ST_GAME_OVER;
`ifdef FROG_GAME_STATE_HISCORE_EN
                        if (w_score_gt_hi) begin
                            w_hi_tens_nxt = r_score_tens;
                            w_hi_ones_nxt = r_score_ones;
                        end
`endif
                    end
                end
            end

            ST_HIT: begin
                // Invulnerable: collisions, goals and start are all ignored.
                // Counter runs 0..FLASH_TICKS-1, so HIT lasts FLASH_TICKS cycles.
                if (r_flash_cnt == c_FLASH_LAST) begin
                    w_flash_cnt_nxt = '0;
                    w_state_nxt     = ST_PLAYING;
                end else begin
                    w_flash_cnt_nxt = r_flash_cnt + c_CNT_ONE;
                end
            end

            ST_GAME_OVER: begin
                // Restart goes straight back into play; IDLE is power-up only.
                if (w_start_evt) begin
                    w_state_nxt      = ST_PLAYING;
                    w_score_tens_nxt = 4'd0;
                    w_score_ones_nxt = 4'd0;
                    w_lives_nxt      = c_LIVES_INIT;
                    w_flash_cnt_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state so they line
        // up exactly with o_State.
        w_flash_nxt     = (w_state_nxt == ST_HIT);
        w_game_over_nxt = (w_state_nxt == ST_GAME_OVER);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state      <= ST_IDLE;
            r_score_tens <= 4'd0;
            r_score_ones <= 4'd0;
            r_lives      <= c_LIVES_INIT;
            r_respawn    <= 1'b0;
            r_flash      <= 1'b0;
            r_game_over  <= 1'b0;
            r_flash_cnt  <= '0;
            r_start      <= 1'b0;
            r_goal       <= 1'b0;
`ifdef FROG_GAME_STATE_HISCORE_EN
            r_hi_tens    <= 4'd0;
            r_hi_ones    <= 4'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_score_tens <= w_score_tens_nxt;
            r_score_ones <= w_score_ones_nxt;
            r_lives      <= w_lives_nxt;
            r_respawn    <= w_respawn_nxt;
            r_flash      <= w_flash_nxt;
            r_game_over  <= w_game_over_nxt;
            r_flash_cnt  <= w_flash_cnt_nxt;
            r_start      <= i_Start;
            r_goal       <= w_at_goal;
`ifdef FROG_GAME_STATE_HISCORE_EN
            r_hi_tens    <= w_hi_tens_nxt;
            r_hi_ones    <= w_hi_ones_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_Score_Tens = r_score_tens;
    assign o_Score_Ones = r_score_ones;
    assign o_Lives      = r_lives;
    assign o_State      = r_state;
    assign o_Respawn    = r_respawn;
    assign o_Flash      = r_flash;
    assign o_Game_Over  = r_game_over;
`ifdef FROG_GAME_STATE_HISCORE_EN
    assign o_Hi_Tens    = r_hi_tens;
    assign o_Hi_Ones    = r_hi_ones;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frog_game_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_frog_game_state
// Purpose  : Self-checking bench for frog_game_state. An event-level game
//            model (integer score, life count, HIT countdown) predicts every
//            output each cycle; directed scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_frog_game_state;

    localparam int c_LIVES = 3;
    localparam int c_GOAL  = 1;
    localparam int c_FT    = 8;

    localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] px = 10'd0;
    logic [9:0] py = 10'd15;
    logic       coll = 1'b0;
    logic [3:0] score_tens, score_ones;
    logic [1:0] lives, state;
    logic       respawn, flash, game_over;
`ifdef FROG_GAME_STATE_HISCORE_EN
    logic [3:0] hi_tens, hi_ones;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frog_game_state #(
        .LIVES_INIT  (c_LIVES),
        .GOAL_ROW    (c_GOAL),
        .FLASH_TICKS (c_FT)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Start      (start),
        .i_Player_X   (px),
        .i_Player_Y   (py),
        .i_Collision  (coll),
        .o_Score_Tens (score_tens),
        .o_Score_Ones (score_ones),
        .o_Lives      (lives),
        .o_State      (state),
        .o_Respawn    (respawn),
        .o_Flash      (flash),
`ifdef FROG_GAME_STATE_HISCORE_EN
        .o_Hi_Tens    (hi_tens),
        .o_Hi_Ones    (hi_ones),
`endif
        .o_Game_Over  (game_over)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural game model, advanced on each rising edge from the inputs
    // that edge sees.
    // ------------------------------------------------------------------------
    int m_mode = M_IDLE;
    int m_score = 0;
    int m_lives = c_LIVES;
    int m_hit_left = 0;
    int m_hi = 0;
    bit m_respawn = 1'b0;
    bit m_prev_start = 1'b0;
    bit m_prev_goal = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit at_goal, start_evt, goal_evt;
        at_goal   = (py == 10'(c_GOAL));
        start_evt = m_prev_start && !start;
        goal_evt  = at_goal && !m_prev_goal;
        m_respawn = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_score = 0; m_lives = c_LIVES; m_hit_left = 0;
            m_hi = 0; m_prev_start = 1'b0; m_prev_goal = 1'b0; m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE, M_OVER: begin
                    if (start_evt) begin
                        m_mode = M_PLAY; m_score = 0; m_lives = c_LIVES;
                    end
                end
                M_PLAY: begin
                    if (goal_evt) begin
                        if (m_score < 99) m_score = m_score + 1;
                    end else if (coll) begin
                        if (m_lives > 1) begin
                            m_lives = m_lives - 1; m_respawn = 1'b1;
                            m_mode = M_HIT; m_hit_left = c_FT;
                        end else begin
                            m_lives = 0; m_mode = M_OVER;
                            if (m_score > m_hi) m_hi = m_score;
                        end
                    end
                end
                default: begin
                    m_hit_left = m_hit_left - 1;
                    if (m_hit_left == 0) m_mode = M_PLAY;
                end
            endcase
            m_prev_start = start;
            m_prev_goal  = at_goal;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("state",     int'(state),      m_mode);
            check("tens",      int'(score_tens), m_score / 10);
            check("ones",      int'(score_ones), m_score % 10);
            check("lives",     int'(lives),      m_lives);
            check("respawn",   int'(respawn),    int'(m_respawn));
            check("flash",     int'(flash),      int'(m_mode == M_HIT));
            check("game_over", int'(game_over),  int'(m_mode == M_OVER));
`ifdef FROG_GAME_STATE_HISCORE_EN
            check("hi_tens",   int'(hi_tens),    m_hi / 10);
            check("hi_ones",   int'(hi_ones),    m_hi % 10);
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
    endtask

    task automatic goal();
        py = 10'd1;  tick(1);
        py = 10'd15; tick(1);
    endtask

    task automatic hit_and_recover();
        coll = 1'b1; tick(1);
        coll = 1'b0; tick(c_FT);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1;
        check("lit_reset_state", int'(state), 0);
        check("lit_reset_lives", int'(lives), 3);
        check("lit_reset_score", int'({score_tens, score_ones}), 0);

        // Start, score 07, get hit, reset mid-HIT
        press_start();
        check("lit_start_state", int'(state), 1);
        check("lit_start_lives", int'(lives), 3);
        repeat (7) goal();
        check("lit_score_07", int'(score_ones), 7);
        coll = 1'b1; tick(1); coll = 1'b0; tick(2);
        check("lit_in_hit", int'(state), 2);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check("lit_midhit_state", int'(state), 0);
        check("lit_midhit_score", int'({score_tens, score_ones}), 0);
        check("lit_midhit_lives", int'(lives), 3);
        check("lit_midhit_flash", int'(flash), 0);

        // Ten goals with carry
        press_start();
        repeat (9) goal();
        check("lit_score_09", int'({score_tens, score_ones}), 8'h09);
        goal();
        check("lit_score_10", int'({score_tens, score_ones}), 8'h10);

        // Goal row held for five cycles scores once
        py = 10'd1; tick(5); py = 10'd15; tick(1);
        check("lit_hold_11", int'({score_tens, score_ones}), 8'h11);

        // Goal and collision together: goal wins
        py = 10'd1; coll = 1'b1; tick(1);
        check("lit_simul_state", int'(state), 1);
        check("lit_simul_lives", int'(lives), 3);
        check("lit_simul_score", int'({score_tens, score_ones}), 8'h12);
        py = 10'd15; coll = 1'b0; tick(1);

        // First collision, held through part of HIT
        coll = 1'b1; tick(1);
        check("lit_hit_respawn", int'(respawn), 1);
        check("lit_hit_lives", int'(lives), 2);
        check("lit_hit_flash", int'(flash), 1);
        tick(3); coll = 1'b0; tick(4);
        check("lit_hit_last_flash", int'(flash), 1);
        check("lit_hit_held_lives", int'(lives), 2);
        tick(1);
        check("lit_hit_exit_state", int'(state), 1);
        check("lit_hit_exit_flash", int'(flash), 0);

        // Second and third collisions -> game over at 12
        hit_and_recover();
        coll = 1'b1; tick(1); coll = 1'b0;
        check("lit_go_state", int'(state), 3);
        check("lit_go_lives", int'(lives), 0);
        check("lit_go_flag", int'(game_over), 1);
        check("lit_go_respawn", int'(respawn), 0);
        goal();
        check("lit_go_frozen", int'({score_tens, score_ones}), 8'h12);

        // Restart, end second game at 05
        press_start();
        check("lit_restart_state", int'(state), 1);
        check("lit_restart_lives", int'(lives), 3);
        check("lit_restart_score", int'({score_tens, score_ones}), 0);
        repeat (5) goal();
        hit_and_recover();
        hit_and_recover();
        coll = 1'b1; tick(1); coll = 1'b0;
        check("lit_go2_score", int'({score_tens, score_ones}), 8'h05);
`ifdef FROG_GAME_STATE_HISCORE_EN
        check("lit_hi_kept", int'({hi_tens, hi_ones}), 8'h12);
`endif

        // Saturation at 99
        press_start();
        repeat (100) goal();
        check("lit_sat_99", int'({score_tens, score_ones}), 8'h99);

        // Randomized play checked by the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 19) == 0) start = ~start;
            coll = ($urandom_range(0, 99) < 6);
            px = 10'($urandom_range(0, 639));
            if (py == 10'd1 && $urandom_range(0, 9) != 0)
                py = 10'($urandom_range(2, 30));
            else if ($urandom_range(0, 7) == 0)
                py = 10'd1;
            else if (py != 10'd1)
                py = 10'($urandom_range(2, 30));
            tick(1);
        end

        rst_n = 1'b1; coll = 1'b0; tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frog_game_state.md
Name: frog_game_state

Overview:
- Game-rules stage directly downstream of the player position block.
- Consumes the player grid position and a per-cycle collision flag from the car/collision checker.
- Tracks score (two BCD digits for the Go Board 7-segment displays) and lives.
- Runs the IDLE/PLAYING/HIT/GAME_OVER state machine and drives the respawn request and sprite flash.

Parameters:
- LIVES_INIT, 3, lives loaded on game start; legal range 1..3.
- GOAL_ROW, 1, player Y value that counts as reaching the far bank.
- FLASH_TICKS, 12500000, cycles spent in HIT (0.5 s at 25 MHz); minimum 2.

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst_n  in  1  synchronous active-low reset.
- i_Start  in  1  debounced start button, active-high; acts on release (1->0).
- i_Player_X  in  10  player column; informational only.
- i_Player_Y  in  10  player row.
- i_Collision  in  1  player cell overlaps a car this cycle.
- o_Score_Tens  out  4  BCD tens digit.
- o_Score_Ones  out  4  BCD ones digit.
- o_Lives  out  2  remaining lives.
- o_State  out  2  00 IDLE, 01 PLAYING, 10 HIT, 11 GAME_OVER.
- o_Respawn  out  1  one-cycle pulse requesting player return to start.
- o_Flash  out  1  player sprite blink enable.
- o_Game_Over  out  1  high while in GAME_OVER.

Behaviour:
- Reset: synchronous, active-low, sampled on posedge i_Clk; reset is one clock with a synchronous active-low reset, fixed.
- Reset values: state IDLE, score 00, o_Lives=LIVES_INIT, o_Respawn=0, o_Flash=0, o_Game_Over=0, flash counter 0, edge registers 0.
- Reset asserted in any state, including mid-HIT: returns to the above on the next edge.
- Start edge: r_Start registers i_Start every cycle; start_evt = r_Start & ~i_Start.
- Goal edge:
  - r_Goal registers (i_Player_Y==GOAL_ROW); goal_evt = (i_Player_Y==GOAL_ROW) & ~r_Goal.
  - The player block holds Y=GOAL_ROW for only one cycle, so detection is single-cycle.
- IDLE:
  - start_evt -> PLAYING; score cleared to 00; lives loaded with LIVES_INIT.
  - Collision and goal are ignored.
- PLAYING, priority order:
  - goal_evt: score +1 in BCD. Ones 9 -> 0 with tens+1; 99 saturates. Stay in PLAYING. A same-cycle i_Collision is ignored; the goal row is safe.
  - i_Collision with o_Lives>1: lives-1, o_Respawn=1 for exactly that next cycle, counter cleared -> HIT.
  - i_Collision with o_Lives==1: lives -> 0 -> GAME_OVER. No respawn pulse.
  - start_evt: ignored.
- HIT:
  - o_Flash=1; counter increments each cycle.
  - When counter==FLASH_TICKS-1: -> PLAYING, counter cleared, o_Flash=0 on that edge.
  - HIT lasts exactly FLASH_TICKS cycles.
  - Collisions, goals and start are ignored; this is invulnerability.
- GAME_OVER:
  - o_Game_Over=1; score frozen, lives 0.
  - start_evt -> PLAYING with score 00 and lives LIVES_INIT. IDLE is not revisited.
- Outputs: all registered; state changes are visible one cycle after the causing input edge.
- Widths: counter wide enough for FLASH_TICKS-1 (24 bits at default). Lives never underflow below 0.

Optional Feature:
- Macro: FROG_GAME_STATE_HISCORE_EN.
- Defined:
  - Adds ports o_Hi_Tens (out 4) and o_Hi_Ones (out 4).
  - On the cycle of entry to GAME_OVER, the high score is loaded with the current score if the current score is strictly greater (BCD compare, tens first).
  - Reset clears it to 00; restarting the game does not clear it.
- Undefined: ports and register absent; behaviour otherwise identical.

Test Plan:
- Reset mid-game: reset low for 1 cycle while in HIT with score 07 -> next cycle state 00, score 00, lives 3, o_Flash 0.
- Start: i_Start 1 then 0 from IDLE -> o_State=01 one cycle later, lives 3, score 00.
- Goals and carry:
  - Ten goal pulses (Y 15 -> 1 -> 15, with Y=1 held one cycle) -> score 10; ones carry correct at 09->10.
  - Y held at 1 for 5 cycles -> only +1.
  - From 99, one more goal -> stays 99.
- Collision with FLASH_TICKS=8:
  - Collision at lives 3 -> o_Respawn high exactly 1 cycle, lives 2, o_Flash high exactly 8 cycles, then o_State=01.
  - Collision held high during HIT -> no further decrement.
- Game over:
  - Third collision -> lives 0, o_State=11, o_Game_Over=1, no respawn pulse.
  - Goal pulse in GAME_OVER -> score unchanged.
  - Start release -> PLAYING, lives 3, score 00.
  - With FROG_GAME_STATE_HISCORE_EN: game ending at 12, then next game ending at 05 -> hi-score remains 12.
- Simultaneous events: goal_evt and i_Collision in the same PLAYING cycle -> score +1, lives unchanged, no HIT.
